// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the streaming multiplexer/arbiter.
package stream_mux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Rotate-priority search: the first requester after ptr (wrapping) wins.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              gnt_valid,
    output logic [CH_W-1:0]   gnt_idx
);

    logic [CH_W-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with packet locking and select or round-robin arbitration.
//   state     | meaning
//   ST_IDLE   | between packets; grant from sel or round-robin search
//   ST_LOCKED | mid-packet; only lock_ch_q may transfer until its last beat
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int DATA_W = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [CH_W-1:0]          sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last,
    input  logic                     out_ready
);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic                out_last_q, out_last_d;

    logic                load_en;
    logic                rr_gnt_valid;
    logic [CH_W-1:0]     rr_gnt_idx;
    logic                gnt_valid;
    logic [CH_W-1:0]     gnt_idx;
    logic [NUM_CH-1:0]   ready_vec;
    logic                accept;
    logic [DATA_W-1:0]   acc_data;
    logic                acc_last;
    logic [31:0]         sel_ext;

    assign load_en = !out_valid_q || out_ready;
    assign sel_ext = 32'(sel);

    rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_rr_arbiter (
        .req      (in_valid),
        .ptr      (rr_ptr_q),
        .gnt_valid(rr_gnt_valid),
        .gnt_idx  (rr_gnt_idx)
    );

    // A held lock overrides both mode and sel.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (state_q == ST_LOCKED) begin
            gnt_valid = 1'b1;
            gnt_idx   = lock_ch_q;
        end else if (mode == MODE_SELECT) begin
            gnt_valid = (sel_ext < 32'(NUM_CH));
            gnt_idx   = sel;
        end else begin
            gnt_valid = rr_gnt_valid;
            gnt_idx   = rr_gnt_idx;
        end
    end

    always_comb begin
        ready_vec = '0;
        acc_data  = '0;
        acc_last  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst && load_en && gnt_valid && (gnt_idx == CH_W'(i)) && in_valid[i]) begin
                ready_vec[i] = 1'b1;
                acc_data     = in_data[i*DATA_W +: DATA_W];
                acc_last     = in_last[i];
            end
        end
    end

    assign accept   = |ready_vec;
    assign in_ready = ready_vec;

    // Pointer moves only on a packet's final beat, so fairness is per packet.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            if (acc_last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = gnt_idx;
            end else begin
                state_d   = ST_LOCKED;
                lock_ch_d = gnt_idx;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_data;
            out_ch_d    = gnt_idx;
            out_last_d  = acc_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

endmodule
